// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: memory-stage load/store unit; splits misaligned accesses into two word beats.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        dmem_size_i,
    input  logic [2:0]        r_size_i,
    input  logic              load_extend_s_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
    state_t state;
    logic we, sext, null_st, acc, split, fin;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata, lo, hi, lo_n, hi_n, sh, ext;
    logic [3:0] pat, pat_n;
    logic [2:0] sz;
    logic [7:0] be_w;
    logic [63:0] wd_w;
    always_comb begin
        sz = we_i ? r_size_i : dmem_size_i;
        null_st = we_i && !(sz == 3'b001 || sz == 3'b010 || sz == 3'b100);
        pat_n = sz == 3'b001 ? 4'b0001 : sz == 3'b010 ? 4'b0011 : 4'b1111;
        // upper nibble / upper word of these shifts belong to the second beat
        be_w = {4'b0000, pat} << addr[1:0];
        wd_w = {32'b0, wdata} << {addr[1:0], 3'b000};
        split = |be_w[7:4];
        acc = state == ACC1 || state == ACC2;
        fin = mem_ack_i && (state == ACC2 || (state == ACC1 && !split));
        lo_n = state == ACC1 ? mem_rdata_i : lo;
        hi_n = state == ACC2 ? mem_rdata_i : hi;
        sh = 32'({hi_n, lo_n} >> {addr[1:0], 3'b000});
        ext = pat == 4'b0001 ? {{24{sext & sh[7]}}, sh[7:0]} :
              pat == 4'b0011 ? {{16{sext & sh[15]}}, sh[15:0]} : sh;
    end
    assign stall_o = !rst && ((state == IDLE && req_i) || acc);
    assign mem_req_o = !rst && acc;
    assign mem_we_o = mem_req_o && we;
    assign mem_be_o = !mem_req_o ? 4'b0000 : state == ACC2 ? be_w[7:4] : be_w[3:0];
    assign mem_addr_o = {addr[ADDR_W-1:2], 2'b00} + (state == ACC2 ? ADDR_W'(4) : '0);
    assign mem_wdata_o = state == ACC2 ? wd_w[63:32] : wd_w[31:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            we <= 1'b0;
            sext <= 1'b0;
            addr <= '0;
            wdata <= '0;
            pat <= '0;
            lo <= '0;
            hi <= '0;
            rdata_o <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            rdata_valid_o <= fin && !we;
            if (fin && !we) rdata_o <= ext;
            if (state == IDLE && req_i) begin
                we <= we_i;
                addr <= addr_i;
                wdata <= wdata_i;
                pat <= pat_n;
                sext <= load_extend_s_i;
                state <= null_st ? DONE : ACC1;
            end else if (state == ACC1 && mem_ack_i) begin
                lo <= mem_rdata_i;
                state <= split ? ACC2 : DONE;
            end else if (state == ACC2 && mem_ack_i) begin
                hi <= mem_rdata_i;
                state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and random loads/stores against a byte-level memory model.
module tb_lsu_mem_ctrl;
    logic clk = 0, rst = 1, req_i = 0, we_i = 0, load_extend_s_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0;
    logic [2:0] dmem_size_i = 0, r_size_i = 0;
    logic stall_o, rdata_valid_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0] mem_be_o;
    logic mem_ack_i = 0;
    int errors = 0, checks = 0, wait_n = 0, cnt = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] q_addr[$], q_wd[$];
    logic [3:0] q_be[$];
    logic q_we[$];
    logic [31:0] h_addr, h_wd, last_load = 0;
    logic [3:0] h_be;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_size_i(dmem_size_i), .r_size_i(r_size_i), .load_extend_s_i(load_extend_s_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;
    assign mem_rdata_i = mem[mem_addr_o[11:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: decides ack at the falling edge so the DUT samples it on the next rising edge.
    always @(negedge clk) begin
        if (mem_req_o) begin
            chk("addr_align", 32'(mem_addr_o[1:0]), 0);
            if (cnt > 0) begin
                chk("hold_addr", mem_addr_o, h_addr);
                chk("hold_be", 32'(mem_be_o), 32'(h_be));
                chk("hold_wdata", mem_wdata_o, h_wd);
            end else begin
                h_addr = mem_addr_o;
                h_be = mem_be_o;
                h_wd = mem_wdata_o;
            end
            if (cnt >= wait_n) begin
                mem_ack_i = 1;
                cnt = 0;
                q_addr.push_back(mem_addr_o);
                q_be.push_back(mem_be_o);
                q_we.push_back(mem_we_o);
                q_wd.push_back(mem_wdata_o);
                if (mem_we_o)
                    for (int l = 0; l < 4; l++)
                        if (mem_be_o[l]) mem[mem_addr_o[11:2]][8*l +: 8] = mem_wdata_o[8*l +: 8];
            end else begin
                mem_ack_i = 0;
                cnt++;
            end
        end else begin
            mem_ack_i = 0;
            cnt = 0;
        end
    end

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return 8'(ref_mem[a[11:2]] >> {a[1:0], 3'b000});
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        mem[a[11:2]] = v;
        ref_mem[a[11:2]] = v;
    endtask

    task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input bit sx, input int wt);
        int n, nb, lat, cyc;
        logic [3:0] ebe [2];
        logic [31:0] ewd [2];
        logic [31:0] eaddr [2];
        logic [31:0] val, b;
        n = w ? (sz == 1 ? 1 : sz == 2 ? 2 : sz == 4 ? 4 : 0) : (sz == 1 ? 1 : sz == 2 ? 2 : 4);
        nb = n == 0 ? 0 : (int'(a[1:0]) + n > 4 ? 2 : 1);
        lat = n == 0 ? 1 : 1 + nb * (wt + 1);
        ebe[0] = 0;
        ebe[1] = 0;
        val = 0;
        for (int i = 0; i < n; i++) begin
            b = a + i;
            ebe[(int'(a[1:0]) + i) >= 4 ? 1 : 0][b[1:0]] = 1'b1;
            if (w) ref_mem[b[11:2]][8*b[1:0] +: 8] = 8'(wd >> (8 * i));
            else val = val | (32'(rbyte(b)) << (8 * i));
        end
        if (!w && sx && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
        eaddr[0] = {a[31:2], 2'b00};
        eaddr[1] = eaddr[0] + 4;
        ewd[0] = wd << (8 * a[1:0]);
        ewd[1] = wd >> (8 * (4 - a[1:0]));
        q_addr.delete();
        q_be.delete();
        q_we.delete();
        q_wd.delete();
        wait_n = wt;
        we_i = w;
        addr_i = a;
        wdata_i = wd;
        dmem_size_i = w ? $urandom : sz;
        r_size_i = w ? sz : $urandom;
        load_extend_s_i = sx;
        req_i = 1;
        #1 chk("stall_on_req", stall_o, 1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (stall_o && cyc < 100);
        chk("latency", cyc, lat);
        chk("rdata_valid", rdata_valid_o, !w);
        if (!w) last_load = val;
        chk("rdata", rdata_o, last_load);
        chk("beats", q_addr.size(), nb);
        for (int k = 0; k < nb && k < q_addr.size(); k++) begin
            chk("beat_addr", q_addr[k], eaddr[k]);
            chk("beat_be", 32'(q_be[k]), 32'(ebe[k]));
            chk("beat_we", 32'(q_we[k]), 32'(w));
            if (w) chk("beat_wdata", q_wd[k], ewd[k]);
        end
        if (w) begin
            chk("mem_word0", mem[a[11:2]], ref_mem[a[11:2]]);
            b = a + 3;
            chk("mem_word1", mem[b[11:2]], ref_mem[b[11:2]]);
        end
        @(posedge clk);
        #1 req_i = 0;
        #1 chk("idle_stall", stall_o, 0);
        chk("idle_req", mem_req_o, 0);
        chk("idle_valid", rdata_valid_o, 0);
    endtask

    initial begin
        logic [2:0] szs [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b100, 3'b010, 3'b001};
        int cyc;
        for (int i = 0; i < 1024; i++) poke(i * 4, $urandom);
        repeat (2) @(posedge clk);
        #1 chk("rst_stall", stall_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_valid", rdata_valid_o, 0);
        rst = 0;
        @(posedge clk);
        #1;
        poke(32'h100, 32'hDEAD_BEEF);
        do_op(0, 32'h100, 0, 3'b100, 0, 0);
        chk("word_load", rdata_o, 32'hDEAD_BEEF);
        poke(32'h100, 32'h80FF_FFFF);
        do_op(0, 32'h103, 0, 3'b001, 1, 0);
        chk("byte_sext", rdata_o, 32'hFFFF_FF80);
        chk("byte_be", 32'(q_be[0]), 32'h8);
        do_op(0, 32'h103, 0, 3'b001, 0, 0);
        chk("byte_zext", rdata_o, 32'h0000_0080);
        do_op(1, 32'h206, 32'h1122_3344, 3'b100, 0, 0);
        chk("st_b1_addr", q_addr[0], 32'h204);
        chk("st_b1_be", 32'(q_be[0]), 32'hC);
        chk("st_b1_wd", q_wd[0], 32'h3344_0000);
        chk("st_b2_addr", q_addr[1], 32'h208);
        chk("st_b2_be", 32'(q_be[1]), 32'h3);
        chk("st_b2_wd", q_wd[1], 32'h0000_1122);
        poke(32'h0FC, 32'hAB00_0000);
        poke(32'h100, 32'h0000_00CD);
        do_op(0, 32'h0FF, 0, 3'b010, 1, 2);
        chk("half_wait", rdata_o, 32'hFFFF_CDAB);
        do_op(0, 32'hFFFF_FFFE, 0, 3'b100, 0, 0);
        chk("wrap_b1", q_addr[0], 32'hFFFF_FFFC);
        chk("wrap_b2", q_addr[1], 32'h0);
        do_op(1, 32'h300, 32'h55, 3'b000, 0, 0);
        // abandon a split load while its second beat is waiting
        wait_n = 4;
        q_addr.delete();
        we_i = 0;
        addr_i = 32'h102;
        dmem_size_i = 3'b100;
        req_i = 1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (q_addr.size() < 1 && cyc < 50);
        chk("mid_first_beat", q_addr.size(), 1);
        chk("mid_in_acc2", mem_addr_o, 32'h104);
        rst = 1;
        req_i = 0;
        #1 chk("rst_hi_stall", stall_o, 0);
        chk("rst_hi_req", mem_req_o, 0);
        @(posedge clk);
        #1 rst = 0;
        last_load = 0;
        for (int i = 0; i < 6; i++) begin
            #1 chk("post_rst_stall", stall_o, 0);
            chk("post_rst_req", mem_req_o, 0);
            chk("post_rst_valid", rdata_valid_o, 0);
            chk("post_rst_rdata", rdata_o, 0);
            @(posedge clk);
        end
        chk("post_rst_beats", q_addr.size(), 1);
        #1;
        for (int i = 0; i < 40; i++)
            do_op($urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                  : $urandom_range(0, 1023), $urandom, szs[$urandom_range(0, 7)],
                  $urandom_range(0, 1), $urandom_range(0, 2));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
